measure_rx: RTL and testbench
=============================

MEASURE_RX -- requirements
Module: measure_rx

Interface
REQ-001 SHALL have parameter MAGIC_CODE, default 40'hCC_55_AA_33_01, the 40-bit signature expected at frame bytes 50-54 (MSB byte first).
REQ-002 SHALL have parameter SEC_CYCLES, default 156250000, the number of sys_clk cycles per measurement window.
REQ-003 SHALL have port sys_clk  in  1  single clock for all logic (156.25 MHz).
REQ-004 SHALL have port sys_rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have port xgmii_rxd  in  64  XGMII receive data; lane 0 = bits 7:0 = first byte on the wire.
REQ-006 SHALL have port xgmii_rxc  in  8  XGMII receive control, 1 bit per lane.
REQ-007 SHALL have port global_counter  in  32  free-running timestamp shared with the transmitter.
REQ-008 SHALL have port rx_pps  out  32  matched frames in the last complete window.
REQ-009 SHALL have port rx_throughput  out  32  matched-frame bytes in the last complete window.
REQ-010 SHALL have port rx_latency  out  24  latency of the most recent matched frame, in cycles.
REQ-011 SHALL have port rx_ipv4_ip  out  32  IPv4 source address of the most recent matched frame.
REQ-012 SHALL have port rx_err_count  out  16  saturating count of aborted frames.

Function
REQ-013 Byte offsets SHALL be counted from the start byte (offset 0); word k SHALL carry bytes 8k..8k+7.
REQ-014 Start SHALL be recognised only when xgmii_rxc==8'h01, rxd[7:0]==8'hFB and rxd[63:56]==8'hD5; lane-4 starts SHALL be ignored.
REQ-015 The FSM SHALL have states IDLE, RECV and DROP.
REQ-016 IDLE->RECV SHALL occur on start, with the word index cleared to 0.
REQ-017 In RECV, the word index SHALL increment each cycle and saturate at 255.
REQ-018 RECV->IDLE SHALL occur on the first lane with rxc=1 and data 8'hFD (terminate); the frame then ends.
REQ-019 RECV->DROP SHALL occur when any lane holds control 8'hFE, or any rxc=1 lane holds anything other than FD, or the word index reaches 255.
REQ-020 DROP->IDLE SHALL occur on terminate or on an all-idle word (rxc=8'hFF, all bytes 8'h07).
REQ-021 A start received while in RECV SHALL abort the current frame (rx_err_count+1) and restart RECV at word index 0.
REQ-022 Bytes 50-54 SHALL be compared against MAGIC_CODE, and bytes 34-37 SHALL be captured as the source IP (byte 34 = IP[31:24]).
REQ-023 Bytes 55-58 SHALL be assembled as the 32-bit timestamp TS (byte 55 = TS[31:24]).
REQ-024 Latency SHALL equal global_counter sampled in the cycle word 7 is present, minus TS, modulo 2^32; the result SHALL saturate to 24'hFFFFFF if bits 31:24 are non-zero.
REQ-025 Frame length SHALL be the byte count from offset 8 up to the byte before FD, inclusive of FCS.
REQ-026 A frame SHALL be matched iff it ends cleanly, the magic code is equal, and its length is >= 64.
REQ-027 One cycle after terminate of a matched frame, rx_latency and rx_ipv4_ip SHALL update, the window frame counter SHALL add 1, and the window byte counter SHALL add the frame length.
REQ-028 Each DROP entry SHALL increment rx_err_count, saturating at 16'hFFFF.
REQ-029 The window timer SHALL count SEC_CYCLES cycles; on expiry, rx_pps and rx_throughput SHALL load the window counters and the counters SHALL clear, all in the same cycle.
REQ-030 A matched frame completing in the expiry cycle SHALL be counted in the new window, not lost.
REQ-031 Window counters SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-032 When sys_rst_n==0 at a clock edge, the FSM SHALL enter IDLE and all outputs, counters and the window timer SHALL become 0.
REQ-033 A reset asserted mid-frame SHALL discard that frame without counting it in rx_err_count; reception SHALL resume at the next valid start after release.

Configuration
REQ-034 With RX_HDR_FILTER_EN defined, a match SHALL additionally require bytes 20-21 == 16'h0800, byte 31 == 8'h11 and bytes 44-45 == 16'h0D5E; a frame failing these checks SHALL be ignored silently (no error count).
REQ-035 With RX_HDR_FILTER_EN undefined, those fields SHALL be ignored and no comparison logic for them SHALL be built.

Verification
REQ-036 Valid 72-byte frame, magic = MAGIC_CODE, TS = global_counter-40 at word 7, src 10.0.0.1 -> rx_latency = 40, rx_ipv4_ip = 32'h0A000001; after expiry rx_pps = 1, rx_throughput = 72.
REQ-037 Same frame with magic byte 54 flipped -> rx_pps = 0, rx_latency unchanged, rx_err_count = 0.
REQ-038 8'hFE control in lane 3 of word 5 -> rx_err_count = 1, no counter change; the next good frame is counted normally.
REQ-039 TS = global_counter-2^24 -> rx_latency = 24'hFFFFFF; TS > global_counter (wrap) with difference 5 -> rx_latency = 5.
REQ-040 SEC_CYCLES=100, matched frame terminating so its update lands in the expiry cycle -> rx_pps of that window excludes it and the next window reports 1.
REQ-041 Reset pulsed mid-frame -> all outputs 0, rx_err_count 0; a following good frame is counted as 1.

Source files
------------

// File: rtl/measure_rx.sv
// measure_rx: XGMII (64-bit, 8 lanes) receive-side frame measurement.
// Detects lane-0 starts, recovers the measurement signature, source IP and
// transmit timestamp from each frame. For every matched frame it reports the
// latency and source address, and it counts matched frames and bytes per
// window of SEC_CYCLES clocks. Aborted frames are counted in rx_err_count.
// Optional build macro: RX_HDR_FILTER_EN adds EtherType/IP-protocol/UDP-port
// qualification to the match; when undefined no such logic is built.
module measure_rx #(
  parameter logic [39:0] MAGIC_CODE = 40'hCC_55_AA_33_01,
  parameter int unsigned SEC_CYCLES = 156250000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] xgmii_rxd,
  input  logic [7:0]  xgmii_rxc,
  input  logic [31:0] global_counter,
  output logic [31:0] rx_pps,
  output logic [31:0] rx_throughput,
  output logic [23:0] rx_latency,
  output logic [31:0] rx_ipv4_ip,
  output logic [15:0] rx_err_count
);

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  localparam logic [31:0] SEC_LAST = SEC_CYCLES - 1;

  state_t      state, state_next;
  logic [7:0]  lane [8];
  logic        ctrl_seen;
  logic [7:0]  first_ctrl;
  logic [2:0]  first_lane;
  logic        is_start, is_term, is_bad, all_idle;
  logic        restart, frame_end, err_event;

  // word_idx lags the bus by one: while in RECV the word on the bus is
  // word_idx+1 (the start word is word 0 and clears word_idx).
  logic [7:0]  word_idx;
  logic        magic_ok;
  logic [7:0]  ts_hi;
  logic [23:0] lat_cand;
  logic [31:0] ip_cap;
  logic        hdr_ok;

  logic [15:0] frame_len;
  logic        match;
  logic [31:0] lat_full;
  logic [23:0] lat_sat;

  logic [31:0] win_timer;
  logic [31:0] win_frames;
  logic [31:0] win_bytes;
  logic [32:0] sum_bytes;
  logic        win_expire;

  // Split the data word into lanes and locate the first control lane.
  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    ctrl_seen  = 1'b0;
    first_ctrl = 8'h00;
    first_lane = 3'd0;
    for (int i = 0; i < 8; i++) begin
      lane[i] = xgmii_rxd[8*i +: 8];
      if (xgmii_rxc[i] && !ctrl_seen) begin
        ctrl_seen  = 1'b1;
        first_ctrl = xgmii_rxd[8*i +: 8];
        first_lane = 3'(i);
      end
    end
  end

  assign is_start = (xgmii_rxc == 8'h01) && (lane[0] == 8'hFB) && (lane[7] == 8'hD5);
  assign is_term  = ctrl_seen && (first_ctrl == 8'hFD);
  assign is_bad   = ctrl_seen && !is_term;
  assign all_idle = (xgmii_rxc == 8'hFF) && (xgmii_rxd == {8{8'h07}});

  // FD sits at byte 8*(word_idx+1)+first_lane; the frame starts at byte 8.
  assign frame_len = {5'd0, word_idx, 3'd0} + {13'd0, first_lane};
  assign match     = frame_end && magic_ok && hdr_ok && (frame_len >= 16'd64);

  // TS spans byte 55 (captured earlier) and bytes 56-58 in lanes 0-2 of word 7.
  assign lat_full = global_counter - {ts_hi, lane[0], lane[1], lane[2]};
  assign lat_sat  = (|lat_full[31:24]) ? 24'hFF_FFFF : lat_full[23:0];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state decode plus per-word control strobes.
  always_comb begin
    state_next = state;
    restart    = 1'b0;
    frame_end  = 1'b0;
    err_event  = 1'b0;
    case (state)
      IDLE: begin
        if (is_start) begin
          state_next = RECV;
          restart    = 1'b1;
        end
      end
      RECV: begin
        if (is_start) begin
          // A new start aborts the frame in flight and reception restarts.
          restart   = 1'b1;
          err_event = 1'b1;
        end else if (is_term) begin
          state_next = IDLE;
          frame_end  = 1'b1;
        end else if (is_bad || (word_idx == 8'hFF)) begin
          state_next = DROP;
          err_event  = 1'b1;
        end
      end
      DROP: begin
        if (is_term || all_idle) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Word index and field capture while a frame is being received.
  // NOTE: the capture registers are ordinary flops, so they are reset along
  // with the rest; only true memory arrays would be left unreset.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      word_idx <= 8'd0;
      magic_ok <= 1'b0;
      ts_hi    <= 8'd0;
      lat_cand <= 24'd0;
      ip_cap   <= 32'd0;
    end else if (restart) begin
      word_idx <= 8'd0;
      magic_ok <= 1'b0;
    end else if (state == RECV) begin
      if (word_idx != 8'hFF) word_idx <= word_idx + 8'd1;
      case (word_idx)
        8'd3: ip_cap <= {lane[2], lane[3], lane[4], lane[5]};
        8'd5: begin
          magic_ok <= ({lane[2], lane[3], lane[4], lane[5], lane[6]} == MAGIC_CODE);
          ts_hi    <= lane[7];
        end
        8'd6: lat_cand <= lat_sat;
        default: ;
      endcase
    end
  end

`ifdef RX_HDR_FILTER_EN
  logic ethertype_ok, proto_ok, port_ok;

  // Header qualification: EtherType IPv4, protocol UDP, UDP port 0x0D5E.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n || restart) begin
      ethertype_ok <= 1'b0;
      proto_ok     <= 1'b0;
      port_ok      <= 1'b0;
    end else if (state == RECV) begin
      case (word_idx)
        8'd1: ethertype_ok <= ({lane[4], lane[5]} == 16'h0800);
        8'd2: proto_ok     <= (lane[7] == 8'h11);
        8'd4: port_ok      <= ({lane[4], lane[5]} == 16'h0D5E);
        default: ;
      endcase
    end
  end

  assign hdr_ok = ethertype_ok && proto_ok && port_ok;
`else
  assign hdr_ok = 1'b1;
`endif

  // Per-frame results, published the cycle after a matched terminate.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      rx_latency <= 24'd0;
      rx_ipv4_ip <= 32'd0;
    end else if (match) begin
      rx_latency <= lat_cand;
      rx_ipv4_ip <= ip_cap;
    end
  end

  // Saturating count of aborted frames.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)                             rx_err_count <= 16'd0;
    else if (err_event && (rx_err_count != '1)) rx_err_count <= rx_err_count + 16'd1;
  end

  assign win_expire = (win_timer == SEC_LAST);
  assign sum_bytes  = {1'b0, win_bytes} + {17'd0, frame_len};

  // Measurement window: publish totals on expiry; a frame matching in that
  // same cycle seeds the new window instead of being lost.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      win_timer     <= 32'd0;
      win_frames    <= 32'd0;
      win_bytes     <= 32'd0;
      rx_pps        <= 32'd0;
      rx_throughput <= 32'd0;
    end else if (win_expire) begin
      win_timer     <= 32'd0;
      rx_pps        <= win_frames;
      rx_throughput <= win_bytes;
      win_frames    <= match ? 32'd1 : 32'd0;
      win_bytes     <= match ? {16'd0, frame_len} : 32'd0;
    end else begin
      win_timer <= win_timer + 32'd1;
      if (match) begin
        if (win_frames != '1) win_frames <= win_frames + 32'd1;
        win_bytes <= sum_bytes[32] ? 32'hFFFF_FFFF : sum_bytes[31:0];
      end
    end
  end

endmodule

// File: tb/tb_measure_rx.sv
// tb_measure_rx: randomized frame traffic for measure_rx with a scoreboard.
// The stimulus side builds each frame byte-by-byte, predicts its outcome from
// the frame rules (match, latency, window membership) and queues the
// expectation; a monitor compares per-frame results and window totals.
module tb_measure_rx;

  localparam int unsigned SEC      = 100;
  localparam logic [39:0] MAGIC    = 40'hCC_55_AA_33_01;
  localparam logic [63:0] IDLE_D   = {8{8'h07}};

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;
  logic [31:0] global_counter;
  logic [31:0] rx_pps;
  logic [31:0] rx_throughput;
  logic [23:0] rx_latency;
  logic [31:0] rx_ipv4_ip;
  logic [15:0] rx_err_count;

  measure_rx #(.MAGIC_CODE(MAGIC), .SEC_CYCLES(SEC)) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .xgmii_rxd      (xgmii_rxd),
    .xgmii_rxc      (xgmii_rxc),
    .global_counter (global_counter),
    .rx_pps         (rx_pps),
    .rx_throughput  (rx_throughput),
    .rx_latency     (rx_latency),
    .rx_ipv4_ip     (rx_ipv4_ip),
    .rx_err_count   (rx_err_count)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int unsigned at;
    logic [23:0] lat;
    logic [31:0] ip;
    logic [15:0] err;
  } exp_t;

  exp_t        fq[$];
  int unsigned win_pps[int unsigned];
  int unsigned win_thr[int unsigned];

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int unsigned edge_no = 0;
  int unsigned drv_edge = 0;
  int unsigned last_e = 0;
  logic [31:0] gc;
  bit          mon_en = 1'b0;
  logic [23:0] m_lat;
  logic [31:0] m_ip;
  logic [15:0] m_err;

  // Edges since reset release; window k closes at edge k*SEC.
  always @(posedge sys_clk) begin
    if (!sys_rst_n) edge_no <= 0;
    else            edge_no <= edge_no + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_no, act, exp);
    end
  endtask

  task automatic drive_word(input logic [63:0] d, input logic [7:0] c);
    @(negedge sys_clk);
    xgmii_rxd      = d;
    xgmii_rxc      = c;
    global_counter = gc;
    gc             = gc + 32'd1;
    drv_edge       = edge_no + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive_word(IDLE_D, 8'hFF);
  endtask

  // len: bytes from offset 8 up to the byte before FD. delta: latency that
  // the embedded TS implies. fe_off >= 8 plants an FE error at that offset.
  // cut > 0 sends only the first cut words and leaves the model untouched.
  task automatic send_frame(input int len, input logic [31:0] ip, input logic [31:0] delta,
                            input bit bad_magic, input int fe_off, input int cut);
    int          fd_off, nw;
    logic [7:0]  fb[];
    bit          fc[];
    logic [7:0]  hdr[int];
    logic [31:0] ts;
    logic [39:0] mg;
    logic [63:0] d;
    logic [7:0]  c;
    bit          matched;
    int unsigned w;
    exp_t        x;

    fd_off = 8 + len;
    nw     = fd_off / 8 + 1;
    fb     = new[nw * 8];
    fc     = new[nw * 8];
    ts     = gc + 32'd7 - delta;
    mg     = MAGIC;
    if (bad_magic) mg[7:0] = ~mg[7:0];

    for (int i = 0; i < nw * 8; i++) begin
      fc[i] = 1'b0;
      if (i == 0)           begin fb[i] = 8'hFB; fc[i] = 1'b1; end
      else if (i < 7)       fb[i] = 8'h55;
      else if (i == 7)      fb[i] = 8'hD5;
      else if (i < fd_off)  fb[i] = 8'($urandom);
      else if (i == fd_off) begin fb[i] = 8'hFD; fc[i] = 1'b1; end
      else                  begin fb[i] = 8'h07; fc[i] = 1'b1; end
    end

    hdr[20] = 8'h08; hdr[21] = 8'h00; hdr[31] = 8'h11;
    hdr[44] = 8'h0D; hdr[45] = 8'h5E;
    for (int j = 0; j < 4; j++) hdr[34 + j] = ip[31 - 8*j -: 8];
    for (int j = 0; j < 5; j++) hdr[50 + j] = mg[39 - 8*j -: 8];
    for (int j = 0; j < 4; j++) hdr[55 + j] = ts[31 - 8*j -: 8];
    foreach (hdr[k]) if (k < fd_off) fb[k] = hdr[k];
    if (fe_off >= 8) begin fb[fe_off] = 8'hFE; fc[fe_off] = 1'b1; end

    for (int wi = 0; wi < nw; wi++) begin
      if (cut > 0 && wi >= cut) break;
      for (int l = 0; l < 8; l++) begin
        d[8*l +: 8] = fb[8*wi + l];
        c[l]        = fc[8*wi + l];
      end
      drive_word(d, c);
    end
    if (cut > 0) return;

    last_e  = drv_edge;
    matched = (fe_off < 8) && !bad_magic && (len >= 64);
    if (fe_off >= 8) m_err = m_err + 16'd1;
    if (matched) begin
      m_lat = (delta >= 32'h0100_0000) ? 24'hFF_FFFF : delta[23:0];
      m_ip  = ip;
      w     = last_e / SEC + 1;
      if (!win_pps.exists(w)) begin win_pps[w] = 0; win_thr[w] = 0; end
      win_pps[w] = win_pps[w] + 1;
      win_thr[w] = win_thr[w] + len;
    end
    x.at = last_e; x.lat = m_lat; x.ip = m_ip; x.err = m_err;
    fq.push_back(x);
  endtask

  // Monitor: window totals at every expiry, per-frame results after the
  // terminate edge of each queued frame.
  exp_t        mx;
  int unsigned mk;
  always @(negedge sys_clk) begin
    if (mon_en && edge_no > 0) begin
      if (edge_no % SEC == 0) begin
        mk = edge_no / SEC;
        check("rx_pps", rx_pps, win_pps.exists(mk) ? win_pps[mk] : 0);
        check("rx_throughput", rx_throughput, win_thr.exists(mk) ? win_thr[mk] : 0);
      end
      while (fq.size() > 0 && fq[0].at == edge_no) begin
        mx = fq.pop_front();
        check("rx_latency", {8'd0, rx_latency}, {8'd0, mx.lat});
        check("rx_ipv4_ip", rx_ipv4_ip, mx.ip);
        check("rx_err_count", {16'd0, rx_err_count}, {16'd0, mx.err});
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, " rx_pps"}, rx_pps, 32'd0);
    check({tag, " rx_throughput"}, rx_throughput, 32'd0);
    check({tag, " rx_latency"}, {8'd0, rx_latency}, 32'd0);
    check({tag, " rx_ipv4_ip"}, rx_ipv4_ip, 32'd0);
    check({tag, " rx_err_count"}, {16'd0, rx_err_count}, 32'd0);
  endtask

  task automatic drain();
    int unsigned tgt;
    tgt = (last_e / SEC + 1) * SEC + 1;
    for (int i = 0; i < 3 * SEC && edge_no < tgt; i++) idle(1);
    check("scoreboard drained", 32'(fq.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          p, r, len, fe;
    logic [31:0] ip, delta;
    bit          bad;

    sys_rst_n = 1'b0;
    xgmii_rxd = IDLE_D;
    xgmii_rxc = 8'hFF;
    gc        = 32'd1000;
    global_counter = 32'd0;
    m_lat = 24'd0; m_ip = 32'd0; m_err = 16'd0;

    idle(3);
    check_all_zero("reset");
    sys_rst_n = 1'b1;
    mon_en    = 1'b1;
    idle(2);

    // Reference frame, then the same with a corrupted signature.
    send_frame(72, 32'h0A00_0001, 32'd40, 1'b0, -1, 0); idle(2);
    send_frame(72, 32'h0A00_0009, 32'd40, 1'b1, -1, 0); idle(2);
    // FE in lane 3 of word 5, then a good frame.
    send_frame(72, 32'h0A00_0002, 32'd100, 1'b0, 43, 0); idle(2);
    send_frame(80, 32'h0A00_0003, 32'd7, 1'b0, -1, 0); idle(2);
    // Latency saturation and timestamp wrap.
    send_frame(72, 32'h0A00_0004, 32'h0100_0000, 1'b0, -1, 0); idle(2);
    gc = 32'hFFFF_FFFB;
    send_frame(72, 32'h0A00_0005, 32'd5, 1'b0, -1, 0); idle(2);
    // Start inside a frame aborts it and the new frame is received.
    send_frame(72, 32'h0A00_0006, 32'd9, 1'b0, -1, 6);
    m_err = m_err + 16'd1;
    send_frame(96, 32'h0A00_0007, 32'd11, 1'b0, -1, 0); idle(2);

    // Matched update landing exactly on the expiry edge, then one edge early.
    idle(1);
    p = int'((SEC - (drv_edge + 11) % SEC) % SEC);
    idle(p);
    send_frame(72, 32'h0A00_0008, 32'd33, 1'b0, -1, 0);
    idle(1);
    p = int'((SEC - (drv_edge + 12) % SEC) % SEC);
    idle(p);
    send_frame(72, 32'h0A00_000A, 32'd34, 1'b0, -1, 0); idle(2);

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      r     = int'($urandom_range(0, 99));
      len   = int'($urandom_range(64, 150));
      ip    = $urandom;
      delta = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 5000);
      bad   = 1'b0;
      fe    = -1;
      if (r < 15)      len = int'($urandom_range(46, 63));
      else if (r < 25) bad = 1'b1;
      else if (r < 40) fe  = 8 * int'($urandom_range(1, (8 + len) / 8 - 1)) + int'($urandom_range(0, 7));
      send_frame(len, ip, delta, bad, fe, 0);
      idle(int'($urandom_range(1, 3)));
    end
    drain();

    // Reset in the middle of a frame.
    mon_en = 1'b0;
    send_frame(72, 32'h0A00_00AA, 32'd20, 1'b0, -1, 5);
    sys_rst_n = 1'b0;
    idle(2);
    check_all_zero("mid-frame reset");
    sys_rst_n = 1'b1;
    m_lat = 24'd0; m_ip = 32'd0; m_err = 16'd0;
    win_pps.delete();
    win_thr.delete();
    fq.delete();
    mon_en = 1'b1;
    idle(2);
    send_frame(72, 32'h0A00_0001, 32'd40, 1'b0, -1, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
